// File: rtl/uart_rx_ctrl_param.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_param
//
// Parametrised serial receiver controller with its own bit-timing datapath.
// Detects and qualifies the start bit, samples each data bit mid-bit from an
// oversampling strobe, checks the stop bit(s), and hands the received word to
// the consumer through a valid/ack handshake. Flags framing, parity (optional)
// and overrun conditions.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : adds the PARITY state and the PARITY_ODD parameter; one parity
//               bit follows the data bits and is checked against the data.
//   undefined : frame is start + data + stop; parity_err is tied to 0.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9), LSB first
//   OVERSAMPLE  sample_tick pulses per bit period (even, >= 4)
//   STOP_BITS   stop bits checked per frame (1 or 2)
//   PARITY_ODD  (feature only) 0 = even parity, 1 = odd parity
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high; clears all state
//   sample_tick  in   one-clock strobe at OVERSAMPLE x baud rate
//   rx_D         in   serial line, idle high, asynchronous to clock
//   rx_ack       in   consumer has taken rx_data; clears rx_valid
//   rx_data      out  last received word, held until the next frame completes
//   rx_valid     out  rx_data holds an unconsumed word
//   rx_available out  high while the controller is idle
//   frame_err    out  stop-bit error on the frame currently in rx_data
//   parity_err   out  parity error on the frame in rx_data
//   overrun      out  sticky: a frame completed while rx_valid was still high
//   dbg_state    out  one-hot FSM state, for observation only
//
// Handshake: rx_valid rises one clock after the last stop-bit sample and stays
// high until a clock on which rx_ack is high. rx_ack while rx_valid is low is
// ignored. If a new word completes on the same clock as rx_ack, the new word
// wins: rx_valid stays high and no overrun is recorded. A new word completing
// while rx_valid is high and rx_ack is low sets the sticky overrun flag.
// -----------------------------------------------------------------------------
module uart_rx_ctrl_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx_D,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_available,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic [5:0]           dbg_state
);

  localparam int TICK_W = $clog2(OVERSAMPLE);

  // Tick-count comparison points. The half-bit point qualifies the start bit;
  // the full-bit point then recurs once per bit period, landing mid-bit.
  localparam logic [TICK_W-1:0] TICK_HALF_M2 = TICK_W'(OVERSAMPLE / 2 - 2);
  localparam logic [TICK_W-1:0] TICK_FULL_M2 = TICK_W'(OVERSAMPLE - 2);
  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(OVERSAMPLE - 1);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_START  = 6'b000010,
    S_DATA   = 6'b000100,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 6'b001000,
`endif
    S_STOP   = 6'b010000,
    S_DONE   = 6'b100000
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_state_change;

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  w_rx_s;

  logic [TICK_W-1:0]     r_tick_cnt;
  logic                  w_half_tick;
  logic                  w_mid_tick;
  logic [3:0]            r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_frame_err_i;

  logic [DATA_BITS-1:0]  r_rx_data;
  logic                  r_rx_valid;
  logic                  r_frame_err;
  logic                  r_overrun;

`ifdef UART_RX_PARITY_EN
  logic                  r_parity_err_i;
  logic                  r_parity_err;
`endif

  assign w_rx_s = r_sync2;

  // Start-bit qualification point and the recurring mid-bit sample point.
  assign w_half_tick = (r_state == S_START) && sample_tick &&
                       (r_tick_cnt == TICK_HALF_M2);
  assign w_mid_tick  = sample_tick && (r_tick_cnt == TICK_FULL_M2);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_next_state = S_START;
        end
      end
      S_START: begin
        // A line that has returned high by half a bit is treated as noise.
        if (w_half_tick) begin
          w_next_state = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_mid_tick && (r_bit_cnt == LAST_DATA)) begin
`ifdef UART_RX_PARITY_EN
          w_next_state = S_PARITY;
`else
          w_next_state = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_mid_tick) begin
          w_next_state = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leave at the last stop-bit sample rather than the end of the stop
        // bit so that a following start edge is not missed.
        if (w_mid_tick && (r_bit_cnt == LAST_STOP)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_state_change = (w_next_state != r_state);

  // ---------------------------------------------------------------------------
  // Synchroniser, bit-timing counters, shift register and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_frame_err_i <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err_i <= 1'b0;
      r_parity_err   <= 1'b0;
`endif
    end else begin
      r_sync1 <= rx_D;
      r_sync2 <= r_sync1;

      // Tick counter restarts on every state entry and wraps explicitly so
      // that non-power-of-two OVERSAMPLE values keep a correct bit period.
      if (w_state_change || (r_state == S_IDLE)) begin
        r_tick_cnt <= '0;
      end else if (sample_tick) begin
        r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
      end

      // Bit counter is shared by DATA and STOP; both start from 0 on entry.
      if (w_state_change) begin
        r_bit_cnt <= '0;
      end else if (w_mid_tick && ((r_state == S_DATA) || (r_state == S_STOP))) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
      if ((r_state == S_DATA) && w_mid_tick) begin
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      end

      if (r_state == S_START) begin
        r_frame_err_i <= 1'b0;
      end else if ((r_state == S_STOP) && w_mid_tick && !w_rx_s) begin
        r_frame_err_i <= 1'b1;
      end

`ifdef UART_RX_PARITY_EN
      if (r_state == S_START) begin
        r_parity_err_i <= 1'b0;
      end else if ((r_state == S_PARITY) && w_mid_tick) begin
        r_parity_err_i <= w_rx_s ^ (^r_shift) ^ PARITY_ODD;
      end
`endif

      if (r_state == S_DONE) begin
        r_rx_data   <= r_shift;
        r_frame_err <= r_frame_err_i;
`ifdef UART_RX_PARITY_EN
        r_parity_err <= r_parity_err_i;
`endif
        r_rx_valid  <= 1'b1;
        if (r_rx_valid && !rx_ack) begin
          r_overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_available = (r_state == S_IDLE);
  assign frame_err    = r_frame_err;
  assign overrun      = r_overrun;
  assign dbg_state    = r_state;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_parity_err;
`else
  assign parity_err   = 1'b0;
`endif

endmodule
